// File: rtl/pccard_host_ctrl.sv
// pccard_host_ctrl: host-side PC Card cycle initiator.
// Turns single-beat requests into timed attribute, common-memory and I/O
// cycles (setup / strobe / hold), captures read data and synchronises the
// card interrupt.
// Optional build macro PCCARD_WAIT_EN adds the cc_wait input: the strobe is
// stretched while the card asserts wait, up to WAIT_TMO extra cycles, after
// which the cycle completes with err=1 and rdata=16'hFFFF.
module pccard_host_ctrl #(
    parameter int T_SETUP  = 2,
    parameter int T_STROBE = 4,
    parameter int T_HOLD   = 1
`ifdef PCCARD_WAIT_EN
    ,
    parameter int WAIT_TMO = 64
`endif
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_space,
    input  logic        req_we,
    input  logic        req_word,
    input  logic [25:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        ack,
    output logic [15:0] rdata,
    output logic        err,
    output logic        irq,
    output logic [25:0] addr,
    output logic [15:0] data_out,
    output logic        data_oe,
    input  logic [15:0] data_in,
    output logic        cc_reg,
    output logic        cc_iord,
    output logic        cc_iowr,
    output logic        cc_oe,
    output logic        cc_we,
    output logic        cc_ce1,
    output logic        cc_ce2,
    input  logic        cc_ireq
`ifdef PCCARD_WAIT_EN
    ,
    input  logic        cc_wait
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_RSVD
    } state_t;

    localparam int              CNT_W     = 8;
    localparam logic [CNT_W-1:0] LD_SETUP  = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_STROBE = CNT_W'(T_STROBE - 1);
    localparam logic [CNT_W-1:0] LD_HOLD   = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [1:0] SP_MEM  = 2'd0;
    localparam logic [1:0] SP_ATTR = 2'd1;
    localparam logic [1:0] SP_IO   = 2'd2;
    localparam logic [1:0] SP_RSVD = 2'd3;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        rdata_q, rdata_d;
    logic               tmo_q, tmo_d;
    logic               accept;

    logic [1:0]         space_q;
    logic               we_q;
    logic               word_q;
    logic [25:0]        addr_q;
    logic [15:0]        wdata_q;

    logic               ireq_s1_q, ireq_s2_q;

    logic               wait_stall;
    logic               wait_tmo;

    logic               busy;
    logic               strobe;
    logic               io_space;

    // Right-justify the addressed byte lane; attribute space has no upper byte.
    function automatic logic [15:0] fmt_rdata(input logic [1:0]  space,
                                              input logic        word,
                                              input logic        odd,
                                              input logic [15:0] din);
        logic [15:0] r;
        if (word) begin
            r = (space == SP_ATTR) ? {8'h00, din[7:0]} : din;
        end else if (odd) begin
            r = {8'h00, din[15:8]};
        end else begin
            r = {8'h00, din[7:0]};
        end
        return r;
    endfunction

    // Place write data on the active lane; odd bytes are replicated so the
    // card sees them on D[15:8].
    function automatic logic [15:0] fmt_wdata(input logic        word,
                                              input logic        odd,
                                              input logic [15:0] wd);
        logic [15:0] r;
        if (word) begin
            r = wd;
        end else if (odd) begin
            r = {wd[7:0], wd[7:0]};
        end else begin
            r = {8'h00, wd[7:0]};
        end
        return r;
    endfunction

`ifdef PCCARD_WAIT_EN
    localparam int WCNT_W = $clog2(WAIT_TMO + 1);

    logic              wait_s1_q, wait_s2_q;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;

    assign wait_stall = wait_s2_q && (wcnt_q != WCNT_W'(WAIT_TMO));
    assign wait_tmo   = wait_s2_q && (wcnt_q == WCNT_W'(WAIT_TMO));

    // Two-flop synchroniser for the asynchronous card wait line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_s1_q <= 1'b0;
            wait_s2_q <= 1'b0;
        end else begin
            wait_s1_q <= cc_wait;
            wait_s2_q <= wait_s1_q;
        end
    end

    // Count strobe-extension cycles; cleared whenever the controller is idle.
    always_comb begin
        wcnt_d = wcnt_q;
        if (state_q == S_IDLE) begin
            wcnt_d = '0;
        end else if (state_q == S_STROBE && cnt_q == '0 && wait_stall) begin
            wcnt_d = wcnt_q + WCNT_W'(1);
        end
    end

    // Wait-extension counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end
`else
    assign wait_stall = 1'b0;
    assign wait_tmo   = 1'b0;
`endif

    // Sequencer: next state, phase counter reload, read capture and timeout flag.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        tmo_d   = tmo_q;
        accept  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    tmo_d  = 1'b0;
                    if (req_space == SP_RSVD) begin
                        state_d = S_RSVD;
                    end else begin
                        state_d = S_SETUP;
                        cnt_d   = LD_SETUP;
                    end
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_STROBE;
                    cnt_d   = LD_STROBE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_STROBE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (!wait_stall) begin
                    state_d = S_HOLD;
                    cnt_d   = LD_HOLD;
                    if (wait_tmo) begin
                        tmo_d   = 1'b1;
                        rdata_d = 16'hFFFF;
                    end else if (!we_q) begin
                        rdata_d = fmt_rdata(space_q, word_q, addr_q[0], data_in);
                    end
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_RSVD: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state, phase counter, read data and timeout flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            tmo_q   <= tmo_d;
        end
    end

    // Latch the request on accept so later changes on req_* are ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            space_q <= SP_MEM;
            we_q    <= 1'b0;
            word_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            space_q <= req_space;
            we_q    <= req_we;
            word_q  <= req_word;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Two-flop synchroniser for the asynchronous card interrupt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ireq_s1_q <= 1'b0;
            ireq_s2_q <= 1'b0;
        end else begin
            ireq_s1_q <= cc_ireq;
            ireq_s2_q <= ireq_s1_q;
        end
    end

    // Card-side outputs decode directly from state so reset removes them at once.
    assign busy     = (state_q == S_SETUP) || (state_q == S_STROBE) || (state_q == S_HOLD);
    assign strobe   = (state_q == S_STROBE);
    assign io_space = (space_q == SP_IO);

    assign req_ready = (state_q == S_IDLE);
    assign ack       = ((state_q == S_HOLD) && (cnt_q == '0)) || (state_q == S_RSVD);
    assign err       = ack && ((state_q == S_RSVD) || tmo_q);
    assign rdata     = rdata_q;
    assign irq       = ireq_s2_q;

    assign addr     = {addr_q[25:1], addr_q[0] & ~word_q};
    assign data_oe  = busy && we_q;
    assign data_out = data_oe ? fmt_wdata(word_q, addr_q[0], wdata_q) : 16'h0000;

    assign cc_reg  = busy && (space_q != SP_MEM);
    assign cc_ce1  = busy && (word_q || !addr_q[0]);
    assign cc_ce2  = busy && (word_q || addr_q[0]);
    assign cc_oe   = strobe && !io_space && !we_q;
    assign cc_we   = strobe && !io_space && we_q;
    assign cc_iord = strobe && io_space && !we_q;
    assign cc_iowr = strobe && io_space && we_q;

endmodule

// File: tb/tb_pccard_host_ctrl.sv
// Self-checking bench for pccard_host_ctrl (default build, fixed timing).
module tb_pccard_host_ctrl;

    localparam int TS   = 2;
    localparam int TST  = 4;
    localparam int TH   = 1;
    localparam int LAT  = TS + TST + TH;
    localparam int PER  = 10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_space;
    logic        req_we;
    logic        req_word;
    logic [25:0] req_addr;
    logic [15:0] req_wdata;
    logic        ack;
    logic [15:0] rdata;
    logic        err;
    logic        irq;
    logic [25:0] addr;
    logic [15:0] data_out;
    logic        data_oe;
    logic [15:0] data_in;
    logic        cc_reg, cc_iord, cc_iowr, cc_oe, cc_we, cc_ce1, cc_ce2;
    logic        cc_ireq;

    int checks = 0;
    int passed = 0;
    logic [15:0] last_rdata;

    pccard_host_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_space (req_space),
        .req_we    (req_we),
        .req_word  (req_word),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .ack       (ack),
        .rdata     (rdata),
        .err       (err),
        .irq       (irq),
        .addr      (addr),
        .data_out  (data_out),
        .data_oe   (data_oe),
        .data_in   (data_in),
        .cc_reg    (cc_reg),
        .cc_iord   (cc_iord),
        .cc_iowr   (cc_iowr),
        .cc_oe     (cc_oe),
        .cc_we     (cc_we),
        .cc_ce1    (cc_ce1),
        .cc_ce2    (cc_ce2),
        .cc_ireq   (cc_ireq)
    );

    always #(PER/2) clk = ~clk;

    initial begin
        #(200000 * PER);
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // Observed control vector: ready, ack, err, reg, iord, iowr, oe, we, ce1, ce2, data_oe.
    function automatic logic [10:0] obs_vec();
        return {req_ready, ack, err, cc_reg, cc_iord, cc_iowr, cc_oe, cc_we, cc_ce1, cc_ce2, data_oe};
    endfunction

    // Reference: read data as the host should present it.
    function automatic logic [15:0] model_rdata(input logic [1:0] sp, input logic word,
                                                input logic a0, input logic [15:0] din);
        if (word) return (sp == 2'd1) ? {8'h00, din[7:0]} : din;
        return a0 ? {8'h00, din[15:8]} : {8'h00, din[7:0]};
    endfunction

    // Reference: expected control vector k cycles after the accept cycle.
    function automatic logic [10:0] model_vec(input int k, input logic [1:0] sp, input logic we,
                                              input logic word, input logic a0);
        logic act, stb, io, mem;
        act = (k >= 1) && (k <= LAT);
        stb = (k > TS) && (k <= TS + TST);
        io  = (sp == 2'd2);
        mem = !io;
        return {!act, (k == LAT), 1'b0, act && (sp != 2'd0),
                stb && io && !we, stb && io && we, stb && mem && !we, stb && mem && we,
                act && (word || !a0), act && (word || a0), act && we};
    endfunction

    // One complete cycle; called at a negedge with the controller idle,
    // returns at the negedge of the first idle cycle after ack.
    task automatic do_txn(input logic [1:0] sp, input logic we, input logic word,
                          input logic [25:0] a, input logic [15:0] wd, input logic [15:0] din,
                          output time t_ack);
        logic [10:0] ev;
        logic [25:0] ea;
        logic [15:0] ed;
        t_ack = 0;
        checks++;
        if (obs_vec() !== 11'b100_0000_0000)
            $display("FAIL idle_before_req got %b exp %b", obs_vec(), 11'b100_0000_0000);
        else passed++;
        req_valid = 1'b1;
        req_space = sp;
        req_we    = we;
        req_word  = word;
        req_addr  = a;
        req_wdata = wd;
        data_in   = 16'($urandom);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            ev = model_vec(k, sp, we, word, a[0]);
            checks++;
            if (obs_vec() !== ev)
                $display("FAIL ctrl_vec k=%0d sp=%0d we=%0d word=%0d got %b exp %b", k, sp, we, word, obs_vec(), ev);
            else passed++;
            ea = word ? {a[25:1], 1'b0} : a;
            checks++;
            if (addr !== ea) $display("FAIL addr k=%0d got %h exp %h", k, addr, ea);
            else passed++;
            if (we) begin
                ed = word ? wd : (a[0] ? {wd[7:0], wd[7:0]} : {8'h00, wd[7:0]});
                checks++;
                if (data_out !== ed) $display("FAIL data_out k=%0d got %h exp %h", k, data_out, ed);
                else passed++;
            end
            if (k == LAT) begin
                t_ack = $time;
                if (!we) begin
                    last_rdata = model_rdata(sp, word, a[0], din);
                    checks++;
                    if (rdata !== last_rdata) $display("FAIL rdata got %h exp %h", rdata, last_rdata);
                    else passed++;
                end
            end
            // Card data only valid on the last strobe cycle; noise elsewhere.
            data_in   = (k == TS + TST) ? din : 16'($urandom);
            req_valid = (k < LAT) ? 1'($urandom) : 1'b0;
            req_space = 2'($urandom);
            req_we    = 1'($urandom);
            req_word  = 1'($urandom);
            req_addr  = 26'($urandom);
            req_wdata = 16'($urandom);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_space = 2'd0;
        req_we    = 1'b0;
        req_word  = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        data_in   = '0;
        cc_ireq   = 1'b0;
        last_rdata = 16'h0000;
        #2;
        checks++;
        if (obs_vec() !== 11'b100_0000_0000) $display("FAIL reset_ctrl got %b exp %b", obs_vec(), 11'b100_0000_0000);
        else passed++;
        checks++;
        if ({rdata, addr, data_out, irq} !== 59'd0) $display("FAIL reset_data got %h exp 0", {rdata, addr, data_out, irq});
        else passed++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", req_ready);
        else passed++;
    endtask

    task automatic test_attr_read();
        time t;
        do_txn(2'd1, 1'b0, 1'b1, 26'h000200, 16'h0000, 16'h0041, t);
        checks++;
        if (rdata !== 16'h0041) $display("FAIL attr_read_rdata got %h exp 0041", rdata);
        else passed++;
    endtask

    task automatic test_space3();
        req_valid = 1'b1;
        req_space = 2'd3;
        req_we    = 1'($urandom);
        req_word  = 1'($urandom);
        req_addr  = 26'($urandom);
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (obs_vec() !== 11'b011_0000_0000) $display("FAIL space3_ack got %b exp %b", obs_vec(), 11'b011_0000_0000);
        else passed++;
        checks++;
        if (rdata !== last_rdata) $display("FAIL space3_rdata got %h exp %h", rdata, last_rdata);
        else passed++;
        @(negedge clk);
        checks++;
        if (obs_vec() !== 11'b100_0000_0000) $display("FAIL space3_after got %b exp %b", obs_vec(), 11'b100_0000_0000);
        else passed++;
    endtask

    task automatic test_io_write();
        time t;
        do_txn(2'd2, 1'b1, 1'b0, 26'h300301, 16'h005A, 16'h0000, t);
    endtask

    task automatic test_back_to_back();
        time t1, t2;
        do_txn(2'd0, 1'b0, 1'b1, 26'h0001234, 16'h0000, 16'hBEEF, t1);
        do_txn(2'd0, 1'b0, 1'b1, 26'h0005678, 16'h0000, 16'hC0DE, t2);
        checks++;
        if ((t2 - t1) !== time'((LAT + 1) * PER)) $display("FAIL b2b_spacing got %0t exp %0t", t2 - t1, (LAT + 1) * PER);
        else passed++;
    endtask

    task automatic test_irq();
        cc_ireq = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b0) $display("FAIL irq_edge1 got %b exp 0", irq);
        else passed++;
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b1) $display("FAIL irq_edge2 got %b exp 1", irq);
        else passed++;
        cc_ireq = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (irq !== 1'b0) $display("FAIL irq_clear got %b exp 0", irq);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1;
        req_space = 2'd0;
        req_we    = 1'b0;
        req_word  = 1'b1;
        req_addr  = 26'h0000100;
        for (int k = 1; k <= TS + 2; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        checks++;
        if (cc_oe !== 1'b1) $display("FAIL rstmid_strobe got %b exp 1", cc_oe);
        else passed++;
        reset_n = 1'b0;
        #1;
        checks++;
        if (obs_vec() !== 11'b100_0000_0000) $display("FAIL rstmid_drop got %b exp %b", obs_vec(), 11'b100_0000_0000);
        else passed++;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (ack !== 1'b0) $display("FAIL rstmid_noack k=%0d got %b exp 0", k, ack);
            else passed++;
        end
        reset_n = 1'b1;
        last_rdata = 16'h0000;
        @(negedge clk);
        checks++;
        if ({req_ready, ack, rdata} !== {1'b1, 1'b0, 16'h0000})
            $display("FAIL rstmid_post got %h exp %h", {req_ready, ack, rdata}, {1'b1, 1'b0, 16'h0000});
        else passed++;
    endtask

    task automatic test_random();
        time t;
        for (int i = 0; i < 40; i++) begin
            do_txn(2'($urandom_range(0, 2)), 1'($urandom), 1'($urandom), 26'($urandom),
                   16'($urandom), 16'($urandom), t);
        end
    endtask

    initial begin
        test_reset();
        test_attr_read();
        test_space3();
        test_io_write();
        test_back_to_back();
        test_irq();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
